// File: rtl/rgb2hsv_div_seq_pkg.sv
// Shared types and constants for the rgb2hsv sequencer: FSM states, hue sectors,
// scaling constants and the sector-to-degrees helper.
package rgb2hsv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StSReq,
    StSWait,
    StHReq,
    StHWait,
    StOut
  } state_e;

  typedef enum logic [1:0] {
    SecR = 2'd0,
    SecG = 2'd1,
    SecB = 2'd2
  } sector_e;

  localparam int unsigned HUE_60    = 60;
  localparam int unsigned HUE_120   = 120;
  localparam int unsigned HUE_240   = 240;
  localparam int unsigned HUE_360   = 360;
  localparam int unsigned SAT_SCALE = 255;

  // Sector base plus/minus the in-sector offset q (0..60), wrapped into 0..359.
  function automatic logic [8:0] hue_from(input sector_e sec, input logic neg,
                                          input logic [6:0] q);
    logic [8:0] base;
    logic [8:0] q9;
    q9 = {2'b00, q};
    case (sec)
      SecR:    base = 9'd0;
      SecG:    base = 9'(HUE_120);
      default: base = 9'(HUE_240);
    endcase
    if (!neg) begin
      hue_from = base + q9;
    end else if (sec == SecR) begin
      hue_from = (q == 7'd0) ? 9'd0 : 9'(HUE_360) - q9;
    end else begin
      hue_from = base - q9;
    end
  endfunction

endpackage

// File: rtl/rgb2hsv_div_seq_if.sv
// Pixel input, divider request/response and HSV output bundle of the rgb2hsv sequencer.
// The slave modport is the sequencer's view; master is the surrounding system's view.
interface rgb2hsv_div_seq_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 32,
  parameter int unsigned H_W    = 9
) ();

  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] r;
  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] b;

  logic              div_enable;
  logic [DIV_W-1:0]  div_a;
  logic [DIV_W-1:0]  div_b;
  logic [DIV_W-1:0]  div_yshang;
  logic [DIV_W-1:0]  div_yyushu;
  logic              div_done;

  logic              hsv_valid;
  logic              hsv_ready;
  logic [H_W-1:0]    h;
  logic [DATA_W-1:0] s;
  logic [DATA_W-1:0] v;

  modport slave (
    input  pix_valid, r, g, b,
    output pix_ready,
    output div_enable, div_a, div_b,
    input  div_yshang, div_yyushu, div_done,
    output hsv_valid, h, s, v,
    input  hsv_ready
  );

  modport master (
    output pix_valid, r, g, b,
    input  pix_ready,
    input  div_enable, div_a, div_b,
    output div_yshang, div_yyushu, div_done,
    input  hsv_valid, h, s, v,
    output hsv_ready
  );

endinterface

// File: rtl/rgb2hsv_div_seq_maxmin.sv
// Combinational max/min/delta and hue-sector extraction for one RGB pixel.
// Ties resolve R over G over B when picking the sector.
module rgb_maxmin
  import rgb2hsv_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] r,
  input  logic [DATA_W-1:0] g,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] max_c,
  output logic [DATA_W-1:0] min_c,
  output logic [DATA_W-1:0] delta,
  output sector_e           sector,
  output logic              sign,
  output logic [DATA_W-1:0] mag
);

  always_comb begin
    max_c  = b;
    sector = SecB;
    sign   = 1'b0;
    mag    = '0;
    if (r >= g && r >= b) begin
      max_c  = r;
      sector = SecR;
      sign   = (g < b);
      mag    = sign ? (b - g) : (g - b);
    end else if (g >= b) begin
      max_c  = g;
      sector = SecG;
      sign   = (b < r);
      mag    = sign ? (r - b) : (b - r);
    end else begin
      max_c  = b;
      sector = SecB;
      sign   = (r < g);
      mag    = sign ? (g - r) : (r - g);
    end
    min_c = (r <= g && r <= b) ? r : ((g <= b) ? g : b);
    delta = max_c - min_c;
  end

endmodule

// File: rtl/rgb2hsv_div_seq.sv
// rgb2hsv sequencer: captures a pixel, drives up to two divides (S then H) and presents HSV.
// Define RGB2HSV_ROUND_EN for round-to-nearest divides; default build truncates.
module rgb2hsv_div_seq
  import rgb2hsv_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 32,
  parameter int unsigned H_W    = 9
) (
  input logic          clk,
  input logic          rst,
  rgb2hsv_div_seq_if.slave bus
);

  state_e            state;
  logic [DATA_W-1:0] r_q, g_q, b_q;

  logic [DATA_W-1:0] max_c, min_c, delta, mag;
  sector_e           sector;
  logic              sign;

  rgb_maxmin #(
    .DATA_W(DATA_W)
  ) u_maxmin (
    .r     (r_q),
    .g     (g_q),
    .b     (b_q),
    .max_c (max_c),
    .min_c (min_c),
    .delta (delta),
    .sector(sector),
    .sign  (sign),
    .mag   (mag)
  );

  logic [DIV_W-1:0] div_q;

`ifdef RGB2HSV_ROUND_EN
  always_comb begin
    div_q = bus.div_yshang;
    if ({bus.div_yyushu, 1'b0} >= {1'b0, bus.div_b}) begin
      div_q = bus.div_yshang + DIV_W'(1);
    end
  end
`else
  logic unused_rem;
  assign div_q      = bus.div_yshang;
  assign unused_rem = ^bus.div_yyushu;
`endif

  // Clamps are no-ops under truncation but bound the rounded quotient.
  logic [DATA_W-1:0] s_next;
  logic [6:0]        q_hue;
  logic [8:0]        hue_next;

  always_comb begin
    s_next   = (div_q > DIV_W'(SAT_SCALE)) ? DATA_W'(SAT_SCALE) : div_q[DATA_W-1:0];
    q_hue    = (div_q > DIV_W'(HUE_60)) ? 7'(HUE_60) : div_q[6:0];
    hue_next = hue_from(sector, sign, q_hue);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= StIdle;
      r_q            <= '0;
      g_q            <= '0;
      b_q            <= '0;
      bus.pix_ready  <= 1'b1;
      bus.div_enable <= 1'b0;
      bus.div_a      <= '0;
      bus.div_b      <= '0;
      bus.hsv_valid  <= 1'b0;
      bus.h          <= '0;
      bus.s          <= '0;
      bus.v          <= '0;
    end else begin
      bus.div_enable <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.pix_valid && bus.pix_ready) begin
            r_q           <= bus.r;
            g_q           <= bus.g;
            b_q           <= bus.b;
            bus.pix_ready <= 1'b0;
            state         <= StCalc;
          end
        end
        StCalc: begin
          bus.v <= max_c;
          if (max_c == '0 || delta == '0) begin
            bus.h         <= '0;
            bus.s         <= '0;
            bus.hsv_valid <= 1'b1;
            state         <= StOut;
          end else begin
            bus.div_enable <= 1'b1;
            bus.div_a      <= DIV_W'(delta) * DIV_W'(SAT_SCALE);
            bus.div_b      <= DIV_W'(max_c);
            state          <= StSReq;
          end
        end
        StSReq: state <= StSWait;
        StSWait: begin
          if (bus.div_done) begin
            bus.s          <= s_next;
            bus.div_enable <= 1'b1;
            bus.div_a      <= DIV_W'(mag) * DIV_W'(HUE_60);
            bus.div_b      <= DIV_W'(delta);
            state          <= StHReq;
          end
        end
        StHReq: state <= StHWait;
        StHWait: begin
          if (bus.div_done) begin
            bus.h         <= H_W'(hue_next);
            bus.hsv_valid <= 1'b1;
            state         <= StOut;
          end
        end
        StOut: begin
          if (bus.hsv_ready) begin
            bus.hsv_valid <= 1'b0;
            bus.pix_ready <= 1'b1;
            state         <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb2hsv_div_seq.sv
// Scoreboard bench for rgb2hsv_div_seq with a behavioural divider model on the div_* bus.
module tb_rgb2hsv_div_seq;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned DIV_W   = 32;
  localparam int unsigned H_W     = 9;
  localparam int          DIV_LAT = 4;

`ifdef RGB2HSV_ROUND_EN
  localparam int H_750 = 43;
`else
  localparam int H_750 = 42;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb2hsv_div_seq_if #(.DATA_W(DATA_W), .DIV_W(DIV_W), .H_W(H_W)) bus ();

  rgb2hsv_div_seq #(
    .DATA_W(DATA_W),
    .DIV_W (DIV_W),
    .H_W   (H_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string name;
    int    h;
    int    s;
    int    v;
    int    ndiv;
    int    en_start;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          errors   = 0;
  int          en_total = 0;
  logic [31:0] op_a[$];
  logic [31:0] op_b[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Divider model: fixed latency, one-cycle done pulse, cleared by rst.
  initial begin
    int          cnt;
    logic [31:0] da, db;
    cnt            = 0;
    da             = 0;
    db             = 1;
    bus.div_done   = 1'b0;
    bus.div_yshang = '0;
    bus.div_yyushu = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.div_done = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt == 1) begin
          bus.div_yshang = da / db;
          bus.div_yyushu = da % db;
          bus.div_done   = 1'b1;
          cnt            = 0;
        end else if (cnt > 1) begin
          check("div_a_hold", int'(bus.div_a), int'(da));
          check("div_b_hold", int'(bus.div_b), int'(db));
          cnt--;
        end
        if (bus.div_enable) begin
          check("div_b_nonzero", int'(bus.div_b != 0), 1);
          da = bus.div_a;
          db = (bus.div_b == 0) ? 32'd1 : bus.div_b;
          op_a.push_back(bus.div_a);
          op_b.push_back(bus.div_b);
          cnt = DIV_LAT;
          en_total++;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.hsv_valid && bus.hsv_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got h=%0d with no pending pixel, required none",
                   bus.h);
        end else begin
          e = sb.pop_front();
          check({e.name, "_h"}, int'(bus.h), e.h);
          check({e.name, "_s"}, int'(bus.s), e.s);
          check({e.name, "_v"}, int'(bus.v), e.v);
          check({e.name, "_ndiv"}, en_total - e.en_start, e.ndiv);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] rv, input logic [7:0] gv, input logic [7:0] bv,
                      input int eh, input int es, input int ev, input int nd,
                      input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.pix_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.pix_ready) begin
      check({name, "_pix_ready_timeout"}, 0, 1);
      return;
    end
    bus.r         = rv;
    bus.g         = gv;
    bus.b         = bv;
    bus.pix_valid = 1'b1;
    sb.push_back('{name: name, h: eh, s: es, v: ev, ndiv: nd, en_start: en_total});
    @(posedge clk);
    #1;
    bus.pix_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({name, "_output_timeout"}, 0, 1);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string name);
    check({name, "_pix_ready"}, int'(bus.pix_ready), 1);
    check({name, "_div_enable"}, int'(bus.div_enable), 0);
    check({name, "_div_a"}, int'(bus.div_a), 0);
    check({name, "_div_b"}, int'(bus.div_b), 0);
    check({name, "_hsv_valid"}, int'(bus.hsv_valid), 0);
    check({name, "_h"}, int'(bus.h), 0);
    check({name, "_s"}, int'(bus.s), 0);
    check({name, "_v"}, int'(bus.v), 0);
  endtask

  task automatic check_latency(input string name);
    int n;
    n = 0;
    while (!bus.hsv_valid && n < 3) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, int'(bus.hsv_valid), 1);
  endtask

  initial begin
    int n;
    bus.pix_valid = 1'b0;
    bus.r         = '0;
    bus.g         = '0;
    bus.b         = '0;
    bus.hsv_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    op_a.delete();
    op_b.delete();
    send(8'd255, 8'd0, 8'd0, 0, 255, 255, 2, "red");
    wait_out("red");
    check("red_op_count", op_a.size(), 2);
    if (op_a.size() == 2) begin
      check("red_op0_a", int'(op_a[0]), 65025);
      check("red_op0_b", int'(op_b[0]), 255);
      check("red_op1_a", int'(op_a[1]), 0);
      check("red_op1_b", int'(op_b[1]), 255);
    end

    send(8'd0, 8'd255, 8'd0, 120, 255, 255, 2, "green");
    wait_out("green");
    send(8'd0, 8'd0, 8'd255, 240, 255, 255, 2, "blue");
    wait_out("blue");

    send(8'd128, 8'd128, 8'd128, 0, 0, 128, 0, "gray");
    check_latency("gray");
    wait_out("gray");
    send(8'd0, 8'd0, 8'd0, 0, 0, 0, 0, "black");
    check_latency("black");
    wait_out("black");

    send(8'd7, 8'd5, 8'd0, H_750, 255, 7, 2, "px750");
    wait_out("px750");
    send(8'd100, 8'd50, 8'd200, 260, 191, 200, 2, "px_blue_sector");
    wait_out("px_blue_sector");

    // Back-pressure on a negative sector-0 hue.
    bus.hsv_ready = 1'b0;
    send(8'd255, 8'd0, 8'd128, 330, 255, 255, 2, "wrap");
    n = 0;
    while (!bus.hsv_valid && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wrap_valid_seen", int'(bus.hsv_valid), 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", int'(bus.hsv_valid), 1);
      check("hold_h", int'(bus.h), 330);
      check("hold_s", int'(bus.s), 255);
      check("hold_v", int'(bus.v), 255);
      check("hold_pix_ready", int'(bus.pix_ready), 0);
    end
    bus.hsv_ready = 1'b1;
    wait_out("wrap");

    // Reset while the hue divide is outstanding.
    send(8'd255, 8'd0, 8'd0, 0, 255, 255, 2, "pre_reset");
    n = 0;
    while ((en_total - sb[0].en_start) < 2 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pre_reset_second_req", en_total - sb[0].en_start, 2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check_reset("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check("post_reset_idle_valid", int'(bus.hsv_valid), 0);
      check("post_reset_idle_enable", int'(bus.div_enable), 0);
    end
    check_reset("post_reset");
    send(8'd0, 8'd255, 8'd0, 120, 255, 255, 2, "green_after_reset");
    wait_out("green_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
